// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream engine.
package rc4_pkg;

    localparam int unsigned SBOX_SIZE  = 256;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DROP_CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_A,
        KSA_B,
        DROP,
        PRGA_A,
        PRGA_B,
        PRGA_C
    } rc4_state_e;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C
    } prga_phase_e;

    function automatic logic is_stream(input rc4_state_e s);
        return (s == PRGA_A) || (s == PRGA_B) || (s == PRGA_C);
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256x8 permutation store: two async read ports, two write ports, port 0 wins on collision.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic [BYTE_W-1:0] rd_addr0,
    output logic [BYTE_W-1:0] rd_data0,
    input  logic [BYTE_W-1:0] rd_addr1,
    output logic [BYTE_W-1:0] rd_data1,
    input  logic              we0,
    input  logic [BYTE_W-1:0] wa0,
    input  logic [BYTE_W-1:0] wd0,
    input  logic              we1,
    input  logic [BYTE_W-1:0] wa1,
    input  logic [BYTE_W-1:0] wd1
);

    logic [BYTE_W-1:0] mem_q [SBOX_SIZE];
    logic [BYTE_W-1:0] mem_d [SBOX_SIZE];

    assign rd_data0 = mem_q[rd_addr0];
    assign rd_data1 = mem_q[rd_addr1];

    // Port 1 applied first so port 0 overwrites it on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (we1) begin
            mem_d[wa1] = wd1;
        end
        if (we0) begin
            mem_d[wa0] = wd0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rc4_stream_engine.sv
// RC4 engine: variable-length key schedule, optional dropN discard, keystream or XOR streaming.
module rc4_stream_engine
    import rc4_pkg::*;
#(
    parameter int unsigned MAX_KEY_BYTES = 16,
    parameter int unsigned DROP_N        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [7:0]                key_length,
    input  logic                      mode,
    input  logic                      din_valid,
    input  logic [7:0]                din,
    output logic                      din_ready,
    output logic                      dout_valid,
    output logic [7:0]                dout,
    input  logic                      dout_ready,
    output logic                      busy,
    output logic                      ready,
    output logic                      err
);

    localparam int unsigned KEY_W  = MAX_KEY_BYTES * BYTE_W;
    localparam int unsigned KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

    rc4_state_e            state_q, state_d;
    prga_phase_e           phase_q, phase_d;
    logic [BYTE_W-1:0]     i_q, i_d;
    logic [BYTE_W-1:0]     j_q, j_d;
    logic [BYTE_W-1:0]     t_q, t_d;
    logic [KIDX_W-1:0]     kidx_q, kidx_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic [7:0]            klen_q, klen_d;
    logic                  mode_q, mode_d;
    logic [BYTE_W-1:0]     dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [BYTE_W-1:0] rd_addr0, rd_addr1, rd_data0, rd_data1;
    logic [BYTE_W-1:0] wa0, wa1, wd0, wd1;
    logic              we0, we1;
    logic [BYTE_W-1:0] key_byte;
    logic              ph_a, ph_b, ph_c, do_swap;
    logic              start_ok, key_bad, rekey, slot_free, stream_go;

    assign key_byte  = key_q[{kidx_q, 3'b000} +: BYTE_W];
    assign start_ok  = start && ((state_q == IDLE) || is_stream(state_q));
    assign key_bad   = (key_length == 8'd0) || (key_length > 8'(MAX_KEY_BYTES));
    assign rekey     = start_ok && !key_bad;
    assign slot_free = !dout_valid_q || dout_ready;
    assign stream_go = (state_q == PRGA_C) && slot_free && (!mode_q || din_valid) && !rekey;
    assign din_ready = (state_q == PRGA_C) && mode_q && slot_free && din_valid && !rekey;

    // PRGA sub-phase decode shared by DROP and STREAM.
    always_comb begin
        ph_a    = (state_q == PRGA_A) || ((state_q == DROP) && (phase_q == PH_A));
        ph_b    = (state_q == PRGA_B) || ((state_q == DROP) && (phase_q == PH_B));
        ph_c    = (state_q == PRGA_C) || ((state_q == DROP) && (phase_q == PH_C));
        do_swap = (state_q == KSA_B) || ph_b;
    end

    always_comb begin
        rd_addr0 = ph_a ? i_q + 8'd1 : i_q;
        rd_addr1 = ph_c ? t_q : j_q;
        we0      = (state_q == INIT) || do_swap;
        wa0      = i_q;
        wd0      = (state_q == INIT) ? i_q : rd_data1;
        we1      = do_swap;
        wa1      = j_q;
        wd1      = rd_data0;
    end

    rc4_sbox u_sbox (
        .clk      (clk),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        i_d          = i_q;
        j_d          = j_q;
        t_d          = t_q;
        kidx_d       = kidx_q;
        drop_cnt_d   = drop_cnt_q;
        key_d        = key_q;
        klen_d       = klen_q;
        mode_d       = mode_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        err_d        = 1'b0;

        if (ph_a) begin
            i_d = i_q + 8'd1;
            j_d = j_q + rd_data0;
        end
        if (ph_b) begin
            t_d = rd_data0 + rd_data1;
        end

        unique case (state_q)
            IDLE: ;
            INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'(SBOX_SIZE - 1)) begin
                    state_d = KSA_A;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            KSA_A: begin
                j_d     = j_q + rd_data0 + key_byte;
                state_d = KSA_B;
            end
            KSA_B: begin
                i_d     = i_q + 8'd1;
                kidx_d  = (8'(kidx_q) == klen_q - 8'd1) ? '0 : kidx_q + KIDX_W'(1);
                state_d = KSA_A;
                if (i_q == 8'(SBOX_SIZE - 1)) begin
                    i_d        = '0;
                    j_d        = '0;
                    drop_cnt_d = '0;
                    phase_d    = PH_A;
                    state_d    = (DROP_N == 0) ? PRGA_A : DROP;
                end
            end
            DROP: begin
                case (phase_q)
                    PH_A:    phase_d = PH_B;
                    PH_B:    phase_d = PH_C;
                    default: begin
                        phase_d = PH_A;
                        if (drop_cnt_q == DROP_CNT_W'(DROP_N - 1)) begin
                            state_d = PRGA_A;
                        end else begin
                            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                        end
                    end
                endcase
            end
            PRGA_A: state_d = PRGA_B;
            PRGA_B: state_d = PRGA_C;
            PRGA_C: begin
                if (stream_go) begin
                    dout_d       = mode_q ? (rd_data1 ^ din) : rd_data1;
                    dout_valid_d = 1'b1;
                    state_d      = PRGA_A;
                end
            end
            default: state_d = IDLE;
        endcase

        // A rejected start leaves everything alone; an accepted one restarts the schedule.
        if (start_ok) begin
            if (key_bad) begin
                err_d = 1'b1;
            end else begin
                state_d      = INIT;
                i_d          = '0;
                j_d          = '0;
                kidx_d       = '0;
                key_d        = key;
                klen_d       = key_length;
                mode_d       = mode;
                dout_valid_d = 1'b0;
            end
        end

        busy_d  = (state_d == INIT) || (state_d == KSA_A) || (state_d == KSA_B) || (state_d == DROP);
        ready_d = is_stream(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= PH_A;
            i_q          <= '0;
            j_q          <= '0;
            t_q          <= '0;
            kidx_q       <= '0;
            drop_cnt_q   <= '0;
            key_q        <= '0;
            klen_q       <= '0;
            mode_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            i_q          <= i_d;
            j_q          <= j_d;
            t_q          <= t_d;
            kidx_q       <= kidx_d;
            drop_cnt_q   <= drop_cnt_d;
            key_q        <= key_d;
            klen_q       <= klen_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Self-checking bench for rc4_stream_engine against a plain RC4 reference model.
module tb_rc4_stream_engine;

    localparam int unsigned MKB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             start0 = 1'b0;
    logic             start1 = 1'b0;
    logic [MKB*8-1:0] key = '0;
    logic [7:0]       key_length = 8'd0;
    logic             mode = 1'b0;
    logic             din_valid = 1'b0;
    logic [7:0]       din = 8'd0;
    logic             dout_ready = 1'b0;

    logic       din_ready0, dout_valid0, busy0, ready0, err0;
    logic [7:0] dout0;
    logic       din_ready1, dout_valid1, busy1, ready1, err1;
    logic [7:0] dout1;

    rc4_stream_engine #(.MAX_KEY_BYTES(MKB), .DROP_N(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .key(key), .key_length(key_length),
        .mode(mode), .din_valid(din_valid), .din(din), .din_ready(din_ready0),
        .dout_valid(dout_valid0), .dout(dout0), .dout_ready(dout_ready),
        .busy(busy0), .ready(ready0), .err(err0)
    );

    rc4_stream_engine #(.MAX_KEY_BYTES(MKB), .DROP_N(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .key(key), .key_length(key_length),
        .mode(mode), .din_valid(din_valid), .din(din), .din_ready(din_ready1),
        .dout_valid(dout_valid1), .dout(dout1), .dout_ready(dout_ready),
        .busy(busy1), .ready(ready1), .err(err1)
    );

    int         passed = 0;
    int         total = 0;
    int         fails = 0;
    int         cyc = 0;
    int         din_idx = 0;
    bit         cap0 = 1'b0;
    bit         cap1 = 1'b0;
    logic [7:0] key_b [32];
    logic [7:0] pt_b  [64];
    logic [7:0] exp_b [64];
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes at the negedge, then return just after the posedge.
    task automatic step();
        @(negedge clk);
        if (cap0 && dout_valid0 && dout_ready) got0.push_back(dout0);
        if (cap0 && din_valid && din_ready0) din_idx++;
        if (cap1 && dout_valid1 && dout_ready) got1.push_back(dout1);
        @(posedge clk);
        #1;
        din = pt_b[(din_idx < 64) ? din_idx : 63];
        cyc++;
    endtask

    task automatic load_key(input logic [255:0] v, input int len);
        for (int b = 0; b < 32; b++) begin
            if (b < len) key_b[b] = v[8*(len-1-b) +: 8];
            else         key_b[b] = 8'h00;
        end
    endtask

    task automatic load_pt(input logic [255:0] v, input int len);
        for (int b = 0; b < 64; b++) begin
            if (b < len) pt_b[b] = v[8*(len-1-b) +: 8];
            else         pt_b[b] = 8'h00;
        end
    endtask

    task automatic load_exp(input logic [255:0] v, input int len);
        for (int b = 0; b < 64; b++) begin
            if (b < len) exp_b[b] = v[8*(len-1-b) +: 8];
            else         exp_b[b] = 8'h00;
        end
    endtask

    // Textbook RC4 (with dropN) producing the expected output bytes into exp_b.
    task automatic model(input int len, input int drop, input int n, input bit md);
        int s [256];
        int i, j, tmp, kb;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(key_b[x % len])) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        i = 0;
        j = 0;
        for (int c = 0; c < drop + n; c++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            kb = s[(s[i] + s[j]) % 256];
            if (c >= drop) exp_b[c-drop] = 8'(kb) ^ (md ? pt_b[c-drop] : 8'h00);
        end
    endtask

    // Pulse start on one DUT; returns in cycle 1 of the new session.
    task automatic do_start(input int which, input int len, input bit md);
        key = '0;
        for (int b = 0; b < int'(MKB); b++) key[8*b +: 8] = key_b[b];
        key_length = 8'(len);
        mode = md;
        cap0 = 1'b0;
        cap1 = 1'b0;
        if (which == 0) start0 = 1'b1;
        else            start1 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        got0.delete();
        got1.delete();
        din_idx = 0;
        din = pt_b[0];
        cyc = 1;
        cap0 = (which == 0);
        cap1 = (which == 1);
    endtask

    task automatic collect(input int n, input int budget, input bit rnd,
                           output int first_v, output int first_r);
        first_v = -1;
        first_r = -1;
        while (got0.size() < n && cyc < budget) begin
            if (first_v < 0 && dout_valid0) first_v = cyc;
            if (first_r < 0 && ready0) first_r = cyc;
            if (rnd) begin
                dout_ready = ($urandom_range(0, 3) != 0);
                din_valid  = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        chk("collect_count", 32'(got0.size()), 32'(n));
    endtask

    task automatic cmp_got(input string tag, input int n);
        logic [31:0] obs;
        for (int k = 0; k < n; k++) begin
            if (k < got0.size()) obs = 32'(got0[k]);
            else                 obs = 32'hFFFF_FFFF;
            chk($sformatf("%s[%0d]", tag, k), obs, 32'(exp_b[k]));
        end
    endtask

    initial begin
        int fv, fr, first1, len;
        bit md, stable;
        logic [7:0] held;

        for (int b = 0; b < 64; b++) pt_b[b] = 8'h00;
        for (int b = 0; b < 32; b++) key_b[b] = 8'h00;
        #1;
        repeat (3) step();
        chk("rst_dout", 32'(dout0), 0);
        chk("rst_dout_valid", 32'(dout_valid0), 0);
        chk("rst_din_ready", 32'(din_ready0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst1_outs", {dout1, 19'd0, dout_valid1, din_ready1, busy1, ready1, err1}, 0);
        rst = 1'b0;
        step();

        // "Key", keystream mode, with latency checks.
        load_key(24'h4B6579, 3);
        load_exp(80'hEB9F7781B734CA72A719, 10);
        dout_ready = 1'b1;
        din_valid = 1'b0;
        do_start(0, 3, 1'b0);
        chk("busy_cycle1", 32'(busy0), 1);
        collect(10, 2000, 1'b0, fv, fr);
        chk("first_valid_cycle", 32'(fv), 772);
        chk("first_ready_cycle", 32'(fr), 769);
        cmp_got("key_ks", 10);

        // "Secret" XOR "Attack at dawn".
        load_key("Secret", 6);
        load_pt("Attack at dawn", 14);
        load_exp(112'h45A01F645FC35B383552544B9BF5, 14);
        din_valid = 1'b1;
        do_start(0, 6, 1'b1);
        collect(14, 2000, 1'b0, fv, fr);
        cmp_got("secret_ct", 14);

        // Five-byte key.
        load_key(40'h0102030405, 5);
        load_exp(64'hB2396305F03DC027, 8);
        din_valid = 1'b0;
        do_start(0, 5, 1'b0);
        collect(8, 2000, 1'b0, fv, fr);
        cmp_got("k5_ks", 8);

        // Drop-4 instance.
        load_key(24'h4B6579, 3);
        do_start(1, 3, 1'b0);
        first1 = -1;
        while (got1.size() < 2 && cyc < 2000) begin
            if (first1 < 0 && dout_valid1) first1 = cyc;
            step();
        end
        chk("drop_first_cycle", 32'(first1), 784);
        chk("drop_byte0", (got1.size() > 0) ? 32'(got1[0]) : 32'hFFFF_FFFF, 32'h B7);
        chk("drop_byte1", (got1.size() > 1) ? 32'(got1[1]) : 32'hFFFF_FFFF, 32'h34);

        // Backpressure then input starvation.
        load_key(24'h4B6579, 3);
        load_pt("Plaintext", 9);
        load_exp(72'hBBF316E8D940AF0AD3, 9);
        dout_ready = 1'b0;
        din_valid = 1'b1;
        do_start(0, 3, 1'b1);
        while (!dout_valid0 && cyc < 2000) step();
        chk("bp_valid", 32'(dout_valid0), 1);
        held = dout0;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (dout0 !== held || din_ready0 !== 1'b0 || dout_valid0 !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        din_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (15) step();
        chk("starve_count", 32'(got0.size()), 1);
        chk("starve_valid", 32'(dout_valid0), 0);
        din_valid = 1'b1;
        collect(9, 3000, 1'b0, fv, fr);
        cmp_got("bp_ct", 9);

        // Rejected start from IDLE.
        rst = 1'b1;
        step();
        rst = 1'b0;
        key_length = 8'd0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("rej_err_pulse", 32'(err0), 1);
        chk("rej_busy", 32'(busy0), 0);
        step();
        chk("rej_err_clear", 32'(err0), 0);
        chk("rej_idle", {30'd0, busy0, ready0}, 0);

        // Rejected start in STREAM keeps the pending byte; then a real rekey drops it.
        load_key(24'h4B6579, 3);
        dout_ready = 1'b0;
        din_valid = 1'b0;
        do_start(0, 3, 1'b0);
        while (!dout_valid0 && cyc < 2000) step();
        key_length = 8'd17;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("rej17_err", 32'(err0), 1);
        chk("rej17_stream", {30'd0, ready0, dout_valid0}, 3);
        load_key("Wiki", 4);
        load_pt("pedia", 5);
        load_exp(40'h1021BF0420, 5);
        din_valid = 1'b1;
        do_start(0, 4, 1'b1);
        chk("rekey_drop_valid", 32'(dout_valid0), 0);
        chk("rekey_busy", 32'(busy0), 1);
        dout_ready = 1'b1;
        collect(5, 2000, 1'b0, fv, fr);
        cmp_got("wiki_ct", 5);

        // Reset in the middle of the key schedule.
        load_key(24'h4B6579, 3);
        do_start(0, 3, 1'b0);
        repeat (400) step();
        chk("ksa_busy", 32'(busy0), 1);
        rst = 1'b1;
        step();
        chk("ksa_rst_outs", {dout0, 19'd0, dout_valid0, din_ready0, busy0, ready0, err0}, 0);
        rst = 1'b0;
        step();

        // Random keys, modes, data and handshake jitter.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 16);
            md  = 1'($urandom_range(0, 1));
            for (int b = 0; b < 32; b++) key_b[b] = 8'($urandom);
            for (int b = 0; b < 64; b++) pt_b[b] = 8'($urandom);
            model(len, 0, 12, md);
            din_valid = 1'b1;
            dout_ready = 1'b1;
            do_start(0, len, md);
            collect(12, 4000, 1'b1, fv, fr);
            cmp_got($sformatf("rand%0d", r), 12);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rc4_stream_engine.md
# rc4_stream_engine

Parametrised RC4 core: generalises the fixed 4-byte-key RC4 design to keys of up to `MAX_KEY_BYTES` bytes, adds an optional RC4-dropN discard phase, and adds a keystream/XOR mode selected per session. It runs the full key schedule on `start`, then streams bytes through valid/ready handshakes. It sits between the key-loading logic and the byte-wide data path as the crypto engine.

## Interface
- `MAX_KEY_BYTES`, 16: key bus width in bytes; legal range 1..32.
- `DROP_N`, 0: number of initial keystream bytes discarded; range 0..1024.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new session; sampled only in IDLE or STREAM.
- `key` in `MAX_KEY_BYTES*8`: key; byte n is bits [8n+7:8n]. Captured when `start` is accepted.
- `key_length` in 8: key bytes used, 1..MAX_KEY_BYTES. Captured with `key`.
- `mode` in 1: 0 = keystream out, 1 = dout = din XOR keystream. Captured with `key`.
- `din_valid` in 1, `din` in 8, `din_ready` out 1: input byte handshake; used only in mode 1.
- `dout_valid` out 1, `dout` out 8, `dout_ready` in 1: output byte handshake.
- `busy` out 1: high in INIT, KSA and DROP.
- `ready` out 1: high in STREAM.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- States:
  - IDLE
  - INIT: 256 cycles, writes S[i]=i.
  - KSA: 256 iterations, 2 cycles each.
  - DROP: DROP_N PRGA iterations, no output.
  - STREAM: PRGA phases A/B/C.
- `start` with `key_length`==0 or `key_length`>MAX_KEY_BYTES: `err` pulses, state stays put, no capture.
- INIT: i counts 0..255, then i=0, j=0, kidx=0.
- KSA iteration:
  - Cycle A: j ← j + S[i] + K[kidx] (mod 256).
  - Cycle B: swap S[i] and S[j]; i++; kidx wraps to 0 at `key_length`-1 (counter, no modulo).
  - After i=255 wraps: i=0, j=0, then DROP (or STREAM if DROP_N=0).
- PRGA iteration:
  - A: i ← i+1; j ← j+S[i+1].
  - B: swap S[i]/S[j]; t ← S[i]+S[j] using pre-swap values.
  - C: k = S[t] read post-swap; t==i or t==j must read the swapped value.
- DROP runs iterations A–B–C and discards k.
- STREAM phase C completes only when the output slot is free (`dout_valid`==0 or `dout_ready`==1). In mode 1 it also requires `din_valid`; `din_ready` is high exactly in that completing C cycle. Otherwise C holds; S, i and j are unchanged.
- On completion of C: `dout` ← k (mode 0) or k^din (mode 1); `dout_valid` ← 1. `dout_valid` drops on the handshake unless a new byte loads in the same cycle.
- i==j swap: both write ports carry the same value; port 0 has priority.
- `start` in STREAM: rekey. Pending `dout_valid` is dropped, go to INIT. `start` in INIT/KSA/DROP is ignored.
- Arithmetic: all i, j, t sums are 8-bit wrap-around.

## Timing
- Reset: state IDLE; i=j=kidx=0; `dout`=0, `dout_valid`=0, `din_ready`=0, `busy`=0, `ready`=0, `err`=0. S contents are not reset.
- `rst` mid-operation: IDLE at the next edge, any output byte discarded.
- `start` accepted at edge 0:
  - `busy` high from cycle 1.
  - INIT cycles 1–256.
  - KSA cycles 257–768.
  - DROP 3·DROP_N cycles.
  - `ready` high from cycle 769+3·DROP_N.
  - First `dout_valid` at cycle 772+3·DROP_N if unstalled.
- Throughput: 1 byte per 3 cycles maximum.
- `dout`/`dout_valid` are registered; `din_ready` is combinational from state and output-slot status.

## Structure
- `rc4_pkg`:
  - State enum (IDLE, INIT, KSA_A, KSA_B, DROP, PRGA_A, PRGA_B, PRGA_C).
  - `SBOX_SIZE=256`.
  - Phase-length localparams.
- Sub-module `rc4_sbox`: 256×8 flop array, two async read ports, two write ports, port 0 priority on address collision.
- Top holds the FSM, counters, key capture and the output register.

## Test plan
- Key "Key" (4B 65 79), `key_length`=3, mode 0, `dout_ready`=1 → EB 9F 77 81 B7 34 CA 72 A7 19; first valid at cycle 772.
- Key "Secret", mode 1, din "Attack at dawn" → 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
- Key 01 02 03 04 05, mode 0 → B2 39 63 05 F0 3D C0 27.
- DROP_N=4, key "Key" → first byte B7, first valid at cycle 784.
- Backpressure and starvation, key "Key" mode 1:
  - Hold `dout_ready`=0 for 20 cycles → `dout` stable, `din_ready`=0.
  - Deassert `din_valid` → no progress.
  - Resume → ciphertext BB F3 16 E8 D9 40 AF 0A D3 for "Plaintext".
- Rejects, rekey and reset:
  - `key_length`=0 → `err` pulse, stays IDLE.
  - `start` mid-STREAM with "Wiki" → `dout_valid` drops, rekey; mode 1 "pedia" → 10 21 BF 04 20.
  - `rst` during KSA → IDLE, all outputs 0 at the next edge.
